// File: rtl/gcd_pkg.sv
// Shared types for the GCD request master: default widths, FSM states and request layout.
package gcd_pkg;

   localparam int GCD_W     = 6;
   localparam int GCD_TAG_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } gcd_state_t;

   typedef struct packed {
      logic [GCD_W-1:0]     a;
      logic [GCD_W-1:0]     b;
      logic [GCD_TAG_W-1:0] tag;
   } gcd_req_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous request FIFO. The pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module gcd_req_fifo
   import gcd_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = gcd_req_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     rdata,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   T            mem [DEPTH];

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   // Pointer update; push and pop may happen in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + 1'b1;
         if (pop && !empty)
            rptr <= rptr + 1'b1;
      end
   end

   // Storage is not reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/gcd_req_master.sv
// Initiator for the subtractive GCD engine. Queues operand pairs, issues them
// one at a time with a start pulse, resolves zero operands locally (the engine
// would never finish on them) and reports an error if the engine hangs.
module gcd_req_master
   import gcd_pkg::*;
#(
   parameter int W       = GCD_W,
   parameter int TAG_W   = GCD_TAG_W,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 80
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [W-1:0]     req_a,
   input  logic [W-1:0]     req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_gcd,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             gcd_start,
   output logic [W-1:0]     gcd_a,
   output logic [W-1:0]     gcd_b,
   input  logic [W-1:0]     gcd_out,
   input  logic             gcd_valid,
   output logic             busy
);

   localparam int CW = $clog2(TIMEOUT);

   typedef struct packed {
      logic [W-1:0]     a;
      logic [W-1:0]     b;
      logic [TAG_W-1:0] tag;
   } req_t;

   gcd_state_t  state;
   logic [CW-1:0] cnt;
   req_t        wr;
   req_t        head;
   logic        full;
   logic        empty;
   logic        pop;

   assign wr.a   = req_a;
   assign wr.b   = req_b;
   assign wr.tag = req_tag;

   assign req_ready = !full;
   // The response slot is always free in IDLE, so the head can be taken at once.
   assign pop  = (state == IDLE) && !empty;
   assign busy = (state != IDLE) || !empty;

   gcd_req_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid),
      .wdata (wr),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // Sequencer: pop, issue to the engine, wait with timeout, hold the response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         gcd_start <= 1'b0;
         gcd_a     <= '0;
         gcd_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_gcd   <= '0;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         gcd_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  rsp_tag <= head.tag;
                  if ((head.a == '0) || (head.b == '0)) begin
                     // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer.
                     rsp_gcd   <= head.a | head.b;
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     gcd_a     <= head.a;
                     gcd_b     <= head.b;
                     gcd_start <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               // cnt==0 is the first WAIT cycle, where valid may still be stale.
               if (gcd_valid && (cnt != '0)) begin
                  rsp_gcd   <= gcd_out;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  rsp_gcd   <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_req_master.sv
// Bench for gcd_req_master: behavioural subtractive engine with a hang switch,
// directed requests, scoreboard of expected responses and engine issues.
module tb_gcd_req_master;

   localparam int W       = 6;
   localparam int TAG_W   = 4;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 80;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [W-1:0]     req_a = '0;
   logic [W-1:0]     req_b = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [W-1:0]     rsp_gcd;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;
   logic             gcd_start;
   logic [W-1:0]     gcd_a;
   logic [W-1:0]     gcd_b;
   logic [W-1:0]     gcd_out;
   logic             gcd_valid;
   logic             busy;
   logic             hang = 1'b0;

   gcd_req_master #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_gcd(rsp_gcd), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
      .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
      .gcd_out(gcd_out), .gcd_valid(gcd_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   // Subtractive engine, not reset; start has priority. hang=1 models a stuck engine.
   logic [W-1:0] ea = '0, eb = '0, eout = '0;
   logic         evalid = 1'b0;
   always @(posedge clk) begin
      if (gcd_start) begin
         ea <= gcd_a; eb <= gcd_b; evalid <= 1'b0;
      end else if (!evalid) begin
         if (ea == eb) begin evalid <= 1'b1; eout <= ea; end
         else if (ea > eb) ea <= ea - eb;
         else eb <= eb - ea;
      end
   end
   assign gcd_out   = eout;
   assign gcd_valid = hang ? 1'b0 : evalid;

   typedef struct {
      logic [W-1:0]     gcd;
      logic [TAG_W-1:0] tag;
      logic             err;
      int               lat;
      int               ref_cyc;
      bit               from_start;
   } exp_t;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } st_t;

   exp_t exp_q[$];
   st_t  st_q[$];
   int   checks = 0;
   int   errors = 0;
   int   last_start = 0;
   bit   prev_v = 1'b0;
   bit   prev_start = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one request; when it is accepted, records what must come back.
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [W-1:0] egcd, input logic eerr, input bit want_rsp,
                       input int lat, input bit from_start);
      exp_t e;
      st_t  s;
      int   waited = 0;
      req_valid = 1'b1; req_a = a; req_b = b; req_tag = tag;
      while (!req_ready && waited < 300) begin tick(); waited++; end
      if (!req_ready) begin
         chk("push_accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      if (want_rsp) begin
         e.gcd = egcd; e.tag = tag; e.err = eerr; e.lat = lat;
         e.ref_cyc = ncyc + 1; e.from_start = from_start;
         exp_q.push_back(e);
      end
      if (a != 0 && b != 0) begin
         s.a = a; s.b = b;
         st_q.push_back(s);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < max_cyc) begin tick(); n++; end
      chk("drain_done", int'(exp_q.size() == 0 && !busy), 1);
   endtask

   // Monitor: checks every presented response and every engine issue.
   always @(negedge clk) begin
      exp_t e;
      st_t  s;
      if (reset) begin
         prev_v     = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (gcd_start) begin
            last_start = ncyc;
            chk("start_single_cycle", int'(prev_start), 0);
            if (st_q.size() == 0) chk("unexpected_start", 1, 0);
            else begin
               s = st_q.pop_front();
               chk("gcd_a", int'(gcd_a), int'(s.a));
               chk("gcd_b", int'(gcd_b), int'(s.b));
            end
         end
         prev_start = gcd_start;
         if (rsp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
               e = exp_q[0];
               chk("rsp_gcd", int'(rsp_gcd), int'(e.gcd));
               chk("rsp_tag", int'(rsp_tag), int'(e.tag));
               chk("rsp_err", int'(rsp_err), int'(e.err));
               if (!prev_v && e.lat >= 0)
                  chk("rsp_latency", ncyc - (e.from_start ? last_start : e.ref_cyc), e.lat);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_v = rsp_valid && !rsp_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      // Reset state
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_outputs", int'({rsp_valid, rsp_err, gcd_start, busy}), 0);
      chk("rst_data", int'({rsp_gcd, rsp_tag, gcd_a, gcd_b}), 0);

      // 1: basic engine op, 2 iterations
      push(6'd12, 6'd18, 4'd3, 6'd6, 1'b0, 1'b1, 6, 1'b0);
      drain(200);

      // 2: engine a==b, then two local zero pairs, back to back
      push(6'd5, 6'd5, 4'd1, 6'd5, 1'b0, 1'b1, 4, 1'b0);
      push(6'd0, 6'd9, 4'd2, 6'd9, 1'b0, 1'b1, -1, 1'b0);
      push(6'd0, 6'd0, 4'd4, 6'd0, 1'b0, 1'b1, -1, 1'b0);
      drain(200);

      // 3: backpressure; the lead request occupies the FSM so the FIFO fills
      rsp_ready = 1'b0;
      push(6'd0, 6'd7, 4'd11, 6'd7, 1'b0, 1'b1, -1, 1'b0);
      push(6'd9, 6'd6, 4'd12, 6'd3, 1'b0, 1'b1, -1, 1'b0);
      push(6'd0, 6'd4, 4'd13, 6'd4, 1'b0, 1'b1, -1, 1'b0);
      push(6'd7, 6'd3, 4'd14, 6'd1, 1'b0, 1'b1, -1, 1'b0);
      push(6'd10, 6'd4, 4'd15, 6'd2, 1'b0, 1'b1, -1, 1'b0);
      chk("full_req_ready", int'(req_ready), 0);
      fork
         push(6'd21, 6'd14, 4'd0, 6'd7, 1'b0, 1'b1, -1, 1'b0);
         begin
            repeat (5) tick();
            chk("held_req_ready", int'(req_ready), 0);
            chk("held_rsp_valid", int'(rsp_valid), 1);
            rsp_ready = 1'b1;
         end
      join
      drain(400);

      // 4: longest legal run, 62 iterations, no timeout
      push(6'd63, 6'd1, 4'd10, 6'd1, 1'b0, 1'b1, 66, 1'b0);
      drain(200);

      // 5: hung engine -> error response TIMEOUT cycles after the ISSUE cycle
      hang = 1'b1;
      push(6'd20, 6'd30, 4'd5, 6'd0, 1'b1, 1'b1, TIMEOUT + 1, 1'b1);
      drain(300);
      hang = 1'b0;
      chk("idle_after_timeout", int'(busy), 0);

      // 6: reset three cycles into WAIT with two requests queued
      push(6'd63, 6'd1, 4'd6, 6'd0, 1'b0, 1'b0, -1, 1'b0);
      push(6'd3, 6'd6, 4'd7, 6'd0, 1'b0, 1'b0, -1, 1'b0);
      push(6'd0, 6'd5, 4'd8, 6'd0, 1'b0, 1'b0, -1, 1'b0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      st_q.delete();
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_rsp_valid", int'(rsp_valid), 0);
      chk("post_rst_req_ready", int'(req_ready), 1);
      repeat (10) tick();
      chk("post_rst_still_idle", int'(busy), 0);
      push(6'd8, 6'd12, 4'd9, 6'd4, 1'b0, 1'b1, 6, 1'b0);
      drain(200);

      chk("exp_q_empty", exp_q.size(), 0);
      chk("start_q_empty", st_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
